// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// and the ALUOp / ALUSrcB / PCSrc mux selects also used by the ALU control decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory access open until MemReady or timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts MemReady-low cycles while a memory state is active and flags the timeout.
module mc_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  logic [7:0] count;

  assign timeout = active && !ready && (count == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= 8'd0;
    else if (!active || ready || timeout)
      count <= 8'd0;
    else
      count <= count + 8'd1;
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core.
// Optional macro MC_BNE_EN adds BNE decoding through the BRANCH state.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       MemErr,
  output logic       IllegalOp
);

  state_t state, next_state;
  logic   timeout;

  mc_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (is_wait_state(state)),
    .ready   (MemReady),
    .timeout (timeout)
  );

`ifdef MC_BNE_EN
  logic bne_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bne_q <= 1'b0;
    else if (state == S_DECODE)
      bne_q <= (Op == OP_BNE);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_FETCH;
    else
      state <= next_state;
  end

  // Everything is held at 0 while reset is asserted, including the FETCH read.
  always_comb begin
    next_state = state;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REGB;
    ALUOp      = ALUOP_ADD;
    PCSrc      = PCSRC_ALU;
    PCEn       = 1'b0;
    MemErr     = 1'b0;
    IllegalOp  = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = MemReady;
          PCEn    = MemReady;
          if (MemReady)
            next_state = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMMSH;
          case (Op)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_RTYPE:     next_state = S_EXECUTE;
            OP_BEQ:       next_state = S_BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:       next_state = S_BRANCH;
`endif
            OP_ADDI:      next_state = S_ADDIEXEC;
            OP_J:         next_state = S_JUMP;
            default: begin
              IllegalOp  = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (MemReady)
            next_state = S_MEMWB;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (MemReady)
            next_state = S_FETCH;
        end
        S_EXECUTE: begin
          ALUSrcA    = 1'b1;
          ALUOp      = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUOp      = ALUOP_SUB;
          PCSrc      = PCSRC_ALUOUT;
`ifdef MC_BNE_EN
          PCEn       = bne_q ? !Zero : Zero;
`else
          PCEn       = Zero;
`endif
          next_state = S_FETCH;
        end
        S_ADDIEXEC: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = PCSRC_JUMP;
          PCEn       = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
      // A timed-out access is abandoned; MemReady low means no IRWrite/PCEn fired.
      if (timeout) begin
        MemErr     = 1'b1;
        next_state = S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed vector table plus randomized run against an instruction-plan reference model.
module tb_mips_multicycle_control;

  localparam int TO = 4;
`ifdef MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
  localparam logic [5:0] BEQ_OP = 6'b000100, BNE_OP = 6'b000101, ADDI_OP = 6'b001000;
  localparam logic [5:0] J_OP = 6'b000010, BAD_OP = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n, Zero, MemReady;
  logic [5:0] Op;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, MemErr, IllegalOp;
  logic [16:0] actual;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .MemErr(MemErr), .IllegalOp(IllegalOp)
  );

  assign actual = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSrc, PCEn, MemErr, IllegalOp};

  function automatic logic [16:0] ov(input logic iord, memrd, memwr, irw, regdst, m2r, regw, srca,
                                     input logic [1:0] srcb, aluop, pcsrc,
                                     input logic pcen, merr, ill);
    return {iord, memrd, memwr, irw, regdst, m2r, regw, srca, srcb, aluop, pcsrc, pcen, merr, ill};
  endfunction

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic z, input logic rdy);
    rst_n = r; Op = op; Zero = z; MemReady = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [16:0] exp);
    checks++;
    if (actual !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, exp);
    end
  endtask

  // Reference model: on a completed fetch the opcode expands into a plan of phases.
  typedef enum int {P_FETCH, P_DECODE, P_ADDR, P_RD, P_RDWB, P_WR, P_EXE, P_ALUWB,
                    P_BR, P_AEXE, P_AWB, P_JMP} phase_t;
  phase_t phase;
  phase_t plan[$];
  int     waited;
  logic   isBne;

  function automatic logic isWaitPhase(input phase_t p);
    return p == P_FETCH || p == P_RD || p == P_WR;
  endfunction

  function automatic logic [16:0] modelOut(input logic r, input logic [5:0] op, input logic z, input logic rdy);
    logic merr;
    logic legal;
    if (!r) return '0;
    merr  = isWaitPhase(phase) && !rdy && (waited == TO - 1);
    legal = op inside {R_OP, LW_OP, SW_OP, BEQ_OP, ADDI_OP, J_OP} || (BNE_EN && op == BNE_OP);
    case (phase)
      P_FETCH:  return ov(0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00,rdy,merr,0);
      P_DECODE: return ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,!legal);
      P_ADDR:   return ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
      P_RD:     return ov(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,merr,0);
      P_RDWB:   return ov(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0);
      P_WR:     return ov(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,merr,0);
      P_EXE:    return ov(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
      P_ALUWB:  return ov(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0);
      P_BR:     return ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,isBne ? !z : z,0,0);
      P_AEXE:   return ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
      P_AWB:    return ov(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0);
      default:  return ov(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
    endcase
  endfunction

  task automatic nextFromPlan();
    if (plan.size() > 0) phase = plan.pop_front();
    else phase = P_FETCH;
  endtask

  task automatic modelStep(input logic r, input logic [5:0] op, input logic rdy);
    if (!r) begin
      phase = P_FETCH; plan.delete(); waited = 0; isBne = 1'b0;
    end else if (isWaitPhase(phase)) begin
      if (rdy) begin
        waited = 0;
        if (phase == P_FETCH) phase = P_DECODE;
        else nextFromPlan();
      end else if (waited == TO - 1) begin
        waited = 0; plan.delete(); phase = P_FETCH;
      end else begin
        waited++;
      end
    end else if (phase == P_DECODE) begin
      plan.delete();
      isBne = 1'b0;
      if (op == R_OP) plan = '{P_EXE, P_ALUWB};
      else if (op == LW_OP) plan = '{P_ADDR, P_RD, P_RDWB};
      else if (op == SW_OP) plan = '{P_ADDR, P_WR};
      else if (op == BEQ_OP) plan = '{P_BR};
      else if (op == ADDI_OP) plan = '{P_AEXE, P_AWB};
      else if (op == J_OP) plan = '{P_JMP};
      else if (BNE_EN && op == BNE_OP) begin plan = '{P_BR}; isBne = 1'b1; end
      nextFromPlan();
    end else begin
      nextFromPlan();
    end
  endtask

  function automatic logic [5:0] pickOp();
    logic [5:0] any;
    any = 6'($urandom_range(0, 63));
    case ($urandom_range(0, 7))
      0: return R_OP;
      1: return LW_OP;
      2: return SW_OP;
      3: return BEQ_OP;
      4: return ADDI_OP;
      5: return J_OP;
      6: return BNE_OP;
      default: return any;
    endcase
  endfunction

  typedef struct {
    string      name;
    logic       rstn;
    logic [5:0] op;
    logic       zero;
    logic       ready;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic addVec(input string n, input logic r, input logic [5:0] op, input logic z,
                        input logic rdy, input logic [16:0] e);
    vec_t v;
    v.name = n; v.rstn = r; v.op = op; v.zero = z; v.ready = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [16:0] fRdy, fWait, fErr, dec, dIll, mAdr, mRd, mRdErr, mWb, mWr, exe, aWb;
    logic [16:0] brT, brN, aExe, adWb, jmp;
    logic [5:0] curOp;
    logic r, z, rdy;

    fRdy   = ov(0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
    fWait  = ov(0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    fErr   = ov(0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,1,0);
    dec    = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
    dIll   = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,1);
    mAdr   = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    mRd    = ov(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    mRdErr = ov(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0);
    mWb    = ov(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0);
    mWr    = ov(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    exe    = ov(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
    aWb    = ov(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0);
    brT    = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0);
    brN    = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,0);
    aExe   = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    adWb   = ov(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0);
    jmp    = ov(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);

    addVec("r_fetch", 1, R_OP, 0, 1, fRdy);
    addVec("r_decode", 1, R_OP, 0, 1, dec);
    addVec("r_execute", 1, R_OP, 0, 1, exe);
    addVec("r_aluwb", 1, R_OP, 0, 1, aWb);
    addVec("lw_fetch", 1, LW_OP, 0, 1, fRdy);
    addVec("lw_decode", 1, LW_OP, 0, 1, dec);
    addVec("lw_memadr", 1, LW_OP, 0, 1, mAdr);
    for (int i = 0; i < 3; i++) addVec("lw_memread_wait", 1, LW_OP, 0, 0, mRd);
    addVec("lw_memread_done", 1, LW_OP, 0, 1, mRd);
    addVec("lw_memwb", 1, LW_OP, 0, 1, mWb);
    addVec("beq_fetch", 1, BEQ_OP, 1, 1, fRdy);
    addVec("beq_decode", 1, BEQ_OP, 1, 1, dec);
    addVec("beq_taken", 1, BEQ_OP, 1, 1, brT);
    addVec("beq_fetch2", 1, BEQ_OP, 0, 1, fRdy);
    addVec("beq_decode2", 1, BEQ_OP, 0, 1, dec);
    addVec("beq_not_taken", 1, BEQ_OP, 0, 1, brN);
    addVec("bne_fetch", 1, BNE_OP, 0, 1, fRdy);
`ifdef MC_BNE_EN
    addVec("bne_decode", 1, BNE_OP, 0, 1, dec);
    addVec("bne_taken", 1, BNE_OP, 0, 1, brT);
`else
    addVec("bne_illegal", 1, BNE_OP, 0, 1, dIll);
`endif
    for (int i = 0; i < 3; i++) addVec("fetch_wait", 1, R_OP, 0, 0, fWait);
    addVec("fetch_timeout", 1, R_OP, 0, 0, fErr);
    addVec("fetch_after_timeout", 1, R_OP, 0, 0, fWait);
    addVec("ill_fetch", 1, BAD_OP, 0, 1, fRdy);
    addVec("ill_decode", 1, BAD_OP, 0, 1, dIll);
    addVec("ill_back_fetch", 1, ADDI_OP, 0, 1, fRdy);
    addVec("addi_decode", 1, ADDI_OP, 0, 1, dec);
    addVec("addi_exec", 1, ADDI_OP, 0, 1, aExe);
    addVec("addi_wb", 1, ADDI_OP, 0, 1, adWb);
    addVec("j_fetch", 1, J_OP, 0, 1, fRdy);
    addVec("j_decode", 1, J_OP, 0, 1, dec);
    addVec("j_jump", 1, J_OP, 0, 1, jmp);
    addVec("sw_fetch", 1, SW_OP, 0, 1, fRdy);
    addVec("sw_decode", 1, SW_OP, 0, 1, dec);
    addVec("sw_memadr", 1, SW_OP, 0, 1, mAdr);
    for (int i = 0; i < 3; i++) addVec("sw_wait", 1, SW_OP, 0, 0, mWr);
    addVec("sw_ready_at_timeout", 1, SW_OP, 0, 1, mWr);
    addVec("lw2_fetch", 1, LW_OP, 0, 1, fRdy);
    addVec("lw2_decode", 1, LW_OP, 0, 1, dec);
    addVec("lw2_memadr", 1, LW_OP, 0, 1, mAdr);
    for (int i = 0; i < 3; i++) addVec("lw2_wait", 1, LW_OP, 0, 0, mRd);
    addVec("lw2_timeout", 1, LW_OP, 0, 0, mRdErr);
    addVec("lw2_abandon_fetch", 1, LW_OP, 0, 0, fWait);

    applyStimulus(0, R_OP, 0, 0);
    checkOutput("reset_outputs", '0);
    @(negedge clk);
    checkOutput("reset_held", '0);
    applyStimulus(1, R_OP, 0, 0);
    checkOutput("reset_release_fetch", fWait);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].op, vecs[i].zero, vecs[i].ready);
      checkOutput(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Reset in the middle of a load: nothing from the load may complete afterwards.
    applyStimulus(0, R_OP, 0, 0);
    @(negedge clk);
    applyStimulus(1, LW_OP, 0, 1); checkOutput("mr_fetch", fRdy); @(negedge clk);
    applyStimulus(1, LW_OP, 0, 1); checkOutput("mr_decode", dec); @(negedge clk);
    applyStimulus(1, LW_OP, 0, 1); checkOutput("mr_memadr", mAdr); @(negedge clk);
    applyStimulus(1, LW_OP, 0, 0); checkOutput("mr_memread", mRd); @(negedge clk);
    applyStimulus(0, LW_OP, 0, 1); checkOutput("mr_reset_zero", '0); @(negedge clk);
    applyStimulus(0, LW_OP, 0, 1); checkOutput("mr_reset_hold", '0); @(negedge clk);
    applyStimulus(1, LW_OP, 0, 0); checkOutput("mr_release_fetch", fWait); @(negedge clk);
    applyStimulus(1, LW_OP, 0, 1); checkOutput("mr_refetch", fRdy); @(negedge clk);
    applyStimulus(1, LW_OP, 0, 1); checkOutput("mr_redecode", dec); @(negedge clk);

    applyStimulus(0, R_OP, 0, 0);
    modelStep(0, R_OP, 0);
    @(negedge clk);
    curOp = R_OP;
    for (int i = 0; i < 2000; i++) begin
      if (phase == P_FETCH) curOp = pickOp();
      z   = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 149) != 0);
      applyStimulus(r, curOp, z, rdy);
      checkOutput($sformatf("rand_%0d", i), modelOut(r, curOp, z, rdy));
      modelStep(r, curOp, rdy);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
